// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N:1 arbitrated multiplexer with valid/ready handshakes.
// Arbitration picks the first requesting channel, searched circularly from
// a pointer. The pointer rotates past each winner in round-robin mode and is
// pinned to 0 in fixed-priority mode. The winner is loaded into a
// single-entry output register that can drain and refill in the same cycle.
module rr_mux_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             hi_found, lo_found;
  logic [SEL_W-1:0] hi_idx, lo_idx;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  logic             xfer;

  // The output register can take a word when empty or being drained.
  assign load_en = !out_valid_q || out_ready;
  // Reset blocks every grant so nothing is handshaken away while resetting.
  assign xfer    = !rst && load_en && grant_any;

  // Circular search from ptr: lowest requester at or above ptr, else the
  // lowest requester overall (the wrapped part of the search).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (in_valid[SEL_W'(c)]) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(c);
        if (SEL_W'(c) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(c);
        end
      end
    end
    grant_any = lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Select the winner's data word; in_ready never looks at data.
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (SEL_W'(c) == grant_idx) sel_data = in_data[c*WIDTH +: WIDTH];
    end
  end

  // One-hot accept towards the winning channel only.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  // Output register and pointer next-state: load beats drain, drain clears valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = grant_idx;
      if (MODE == 0) begin
        ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset empties the output and restarts the pointer at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: three instances (round-robin x4, fixed priority x4,
// round-robin x3) share stimulus and are compared against a behavioural model.
module tb_rr_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  vld;
  logic        ordy;
  logic [15:0] din [4];
  logic [63:0] din_pk;

  always_comb begin
    din_pk = {din[3], din[2], din[1], din[0]};
  end

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [15:0] od0, od1, od2;
  logic [1:0]  os0, os1, os2;
  logic        ov0, ov1, ov2;

  rr_mux_arb #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(din_pk), .in_valid(vld), .in_ready(rdy0),
    .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(ordy));

  rr_mux_arb #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_data(din_pk), .in_valid(vld), .in_ready(rdy1),
    .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(ordy));

  rr_mux_arb #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .in_data(din_pk[47:0]), .in_valid(vld[2:0]), .in_ready(rdy2),
    .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(ordy));

  // Uniform views of the three instances for the model comparison loop.
  logic [3:0]  obs_rdy [3];
  logic [15:0] obs_od  [3];
  logic [3:0]  obs_os  [3];
  logic        obs_ov  [3];
  logic [3:0]  obs_ptr [3];

  assign obs_rdy[0] = rdy0;
  assign obs_rdy[1] = rdy1;
  assign obs_rdy[2] = {1'b0, rdy2};
  assign obs_od[0]  = od0;
  assign obs_od[1]  = od1;
  assign obs_od[2]  = od2;
  assign obs_os[0]  = {2'b00, os0};
  assign obs_os[1]  = {2'b00, os1};
  assign obs_os[2]  = {2'b00, os2};
  assign obs_ov[0]  = ov0;
  assign obs_ov[1]  = ov1;
  assign obs_ov[2]  = ov2;
  assign obs_ptr[0] = {2'b00, u0.ptr_q};
  assign obs_ptr[1] = {2'b00, u1.ptr_q};
  assign obs_ptr[2] = {2'b00, u2.ptr_q};

  localparam int NCH [3] = '{4, 4, 3};
  localparam int MD  [3] = '{0, 1, 0};

  // Behavioural model state per instance.
  int          m_ptr [3];
  logic        m_ov  [3];
  logic [15:0] m_od  [3];
  int          m_os  [3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // First requesting channel searched circularly from the pointer, -1 if none.
  function automatic int winner(input int i, input logic [3:0] v);
    for (int k = 0; k < NCH[i]; k++) begin
      int idx;
      idx = (m_ptr[i] + k) % NCH[i];
      if (((v >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  // One clock: check current outputs and grants, advance the model on the edge.
  task automatic step();
    int          w;
    logic        load;
    logic [3:0]  v, msk, exp_rdy;
    logic [3:0]  one;
    int          n_ptr [3];
    logic        n_ov  [3];
    logic [15:0] n_od  [3];
    int          n_os  [3];
    one = 4'b0001;
    #2;
    for (int i = 0; i < 3; i++) begin
      msk     = (NCH[i] == 4) ? 4'hF : 4'h7;
      v       = vld & msk;
      w       = winner(i, v);
      load    = !m_ov[i] || ordy;
      exp_rdy = (!rst && load && w >= 0) ? (one << w) : 4'b0000;
      chk($sformatf("in_ready[%0d]", i), 32'(obs_rdy[i]), 32'(exp_rdy));
      chk($sformatf("out_valid[%0d]", i), 32'(obs_ov[i]), 32'(m_ov[i]));
      chk($sformatf("out_data[%0d]", i), 32'(obs_od[i]), 32'(m_od[i]));
      chk($sformatf("out_sel[%0d]", i), 32'(obs_os[i]), 32'(m_os[i]));
      chk($sformatf("ptr[%0d]", i), 32'(obs_ptr[i]), 32'(m_ptr[i]));
      n_ptr[i] = m_ptr[i];
      n_ov[i]  = m_ov[i];
      n_od[i]  = m_od[i];
      n_os[i]  = m_os[i];
      if (rst) begin
        n_ov[i]  = 1'b0;
        n_od[i]  = 16'h0000;
        n_os[i]  = 0;
        n_ptr[i] = 0;
      end else if (load && w >= 0) begin
        n_ov[i] = 1'b1;
        n_od[i] = din[w[1:0]];
        n_os[i] = w;
        if (MD[i] == 0) n_ptr[i] = (w + 1) % NCH[i];
      end else if (m_ov[i] && ordy) begin
        n_ov[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = n_ptr[i];
      m_ov[i]  = n_ov[i];
      m_od[i]  = n_od[i];
      m_os[i]  = n_os[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = 0;
      m_ov[i]  = 1'b0;
      m_od[i]  = 16'h0000;
      m_os[i]  = 0;
    end
    for (int c = 0; c < 4; c++) din[c] = 16'h00A0 + 16'(c);
    rst  = 1'b1;
    vld  = 4'b1111;
    ordy = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with every channel requesting.
    for (int k = 0; k < 2; k++) step();

    // Round-robin rotation under full load.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rot_sel0", 32'(os0), 32'(k % 4));
      chk("rot_dat0", 32'(od0), 32'(16'h00A0 + 16'(k % 4)));
      chk("prio_sel1", 32'(os1), 32'd0);
      chk("rot_sel2", 32'(os2), 32'(k % 3));
    end

    // Backpressure: output full and stalled, channels 1 and 2 requesting.
    ordy = 1'b0;
    vld  = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold0", 32'(od0), 32'h00A1);
    end
    ordy = 1'b1;
    step();
    chk("bp_next0", 32'(os0), 32'd2);

    // Sparse requests: grant 1, wrap to 0, then skip ahead to 3.
    vld = 4'b0010;
    step();
    chk("sp_g1", 32'(os0), 32'd1);
    vld = 4'b0001;
    step();
    chk("sp_wrap0", 32'(os0), 32'd0);
    chk("sp_ptr0", 32'(u0.ptr_q), 32'd1);
    vld = 4'b1001;
    step();
    chk("sp_skip3", 32'(os0), 32'd3);

    // Fixed priority starves channel 3.
    vld = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fp_sel1", 32'(os1), 32'd1);
    end

    // Mid-stream reset, then full load on the three-channel instance.
    vld = 4'b1111;
    step();
    rst = 1'b1;
    step();
    chk("mr_valid2", 32'(ov2), 32'd0);
    chk("mr_ptr2", 32'(u2.ptr_q), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mr_sel2", 32'(os2), 32'(k % 3));
    end

    // Randomised traffic, backpressure and occasional resets.
    for (int k = 0; k < 400; k++) begin
      vld  = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 4; c++) din[c] = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
